// File: rtl/mem_arb2.sv
// mem_arb2: shares one single-port memory between I-fetch and D load/store ports.
// Defining MEM_ARB_RR_EN selects round-robin; otherwise D has priority, with a starvation guard for I.
module mem_arb2 #(
  parameter int WORD   = 32,
  parameter int ADDR   = 16,
  parameter int STARVE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [ADDR-1:0] i_addr,
  output logic            i_ack,
  output logic            i_rvalid,
  output logic [WORD-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [ADDR-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_ack,
  output logic            d_rvalid,
  output logic [WORD-1:0] d_rdata,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);
  logic            i_win;
  logic            tag_v;
  logic            tag_d;
  logic [WORD-1:0] i_hold;
  logic [WORD-1:0] d_hold;
`ifdef MEM_ARB_RR_EN
  logic ptr_d;
  assign i_win = i_req && (!d_req || !ptr_d);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_d <= 1'b0;
    else if (i_ack || d_ack) ptr_d <= i_ack;
`else
  logic [3:0] starve;
  assign i_win = i_req && (!d_req || starve == 4'(STARVE));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve <= '0;
    else starve <= (i_req && !i_ack) ? ((starve == 4'(STARVE)) ? starve : starve + 4'd1) : '0;
`endif
  // Grants are masked during reset so nothing reaches the memory while rst_n is low.
  assign i_ack    = rst_n && i_win;
  assign d_ack    = rst_n && d_req && !i_win;
  assign mem_a    = i_ack ? i_addr : (d_ack ? d_addr : '0);
  assign mem_w    = d_ack && d_we;
  assign mem_d    = d_ack ? d_wdata : '0;
  assign i_rvalid = tag_v && !tag_d;
  assign d_rvalid = tag_v && tag_d;
  assign i_rdata  = i_rvalid ? mem_q : i_hold;
  assign d_rdata  = d_rvalid ? mem_q : d_hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag_v  <= 1'b0;
      tag_d  <= 1'b0;
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      tag_v <= i_ack || (d_ack && !d_we);
      tag_d <= d_ack;
      if (i_rvalid) i_hold <= mem_q;
      if (d_rvalid) d_hold <= mem_q;
    end
endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-port access arbiter for the single-port 32-bit x 64K on-chip memory of the venus processor. It shares the memory between the instruction-fetch port (I) and the load/store data port (D). Each cycle it picks at most one requester and drives the memory address, write-enable and write-data lines. It routes the one-cycle-late read data back to the port that issued the read.

## Interface
- WORD, 32, data width (matches memory word)
- ADDR, 16, address width (matches memory depth)
- STARVE, 4, consecutive denied I-cycles before I is forced ahead of D (priority mode only); range 1..15
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-port read request, held until i_ack
- i_addr  in  ADDR  I-port address, held with i_req
- i_ack  out  1  I-port grant, combinational, same cycle as issue
- i_rvalid  out  1  I-port read data valid, one cycle after grant
- i_rdata  out  WORD  I-port read data
- d_req  in  1  D-port request, held until d_ack
- d_we  in  1  D-port write (1) / read (0)
- d_addr  in  ADDR  D-port address
- d_wdata  in  WORD  D-port write data
- d_ack  out  1  D-port grant, combinational
- d_rvalid  out  1  D-port read data valid (reads only)
- d_rdata  out  WORD  D-port read data
- mem_a  out  ADDR  to memory A
- mem_w  out  1  to memory W
- mem_d  out  WORD  to memory D
- mem_q  in  WORD  from memory Q (registered; valid the cycle after a read issue; unchanged by writes)

## Operation
- Grant is combinational from req and the arbitration state; at most one of i_ack/d_ack high per cycle; ack implies the access is issued at this clock edge.
- Granted port drives mem_a/mem_w/mem_d; I port always mem_w=0. No grant: mem_a=0, mem_w=0, mem_d=0.
- Arbitration (priority mode): D wins over I, except when starve counter == STARVE, then I wins.
- Starve counter (4 bits): increments each cycle i_req=1 and i_ack=0, saturates at STARVE; clears on i_ack or i_req=0.
- Read tag register {valid, port}: loaded at each edge with the current grant (valid=1 only for a read). In the next cycle, the tagged port sees x_rvalid=1 and x_rdata=mem_q. The same value is captured into that port's hold register.
- x_rdata outside an rvalid cycle shows the port's hold register (last read value, stable).
- Back-to-back issue every cycle is allowed; a write in the cycle after a read does not disturb the returning data.
- Memory ordering is program order of issue: write at T then read same address at T+1 returns new data. Read at T then write at T+1 returns old data.

## Timing
- Reset (rst_n=0, asynchronous): tag valid=0, starve counter=0, round-robin pointer=I, hold registers=0. i_rvalid=d_rvalid=0, i_rdata=d_rdata=0. i_ack=d_ack=0 and mem_w=0 are forced while rst_n=0.
- Grant latency 0 cycles (ack combinational with req when won); read latency 1 cycle from ack to rvalid.
- Throughput: one access per cycle total.
- Reset asserted with a read in flight: tag cleared, no rvalid after release.
- req dropped without ack: legal; nothing issued, counter clears.
- Both ports request continuously in priority mode: I granted exactly once every STARVE+1 cycles.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit pointer names the preferred port; on any grant the pointer moves to the other port. If only one port requests, it wins regardless. Starve counter and STARVE are not built.
- Undefined: fixed D-over-I priority with starve counter as above.

## Test plan
- Reset release, no requests -> all acks/rvalid 0, mem_w=0, mem_a=0, rdata=0 for 10 cycles.
- D write 0xDEADBEEF @0x0010 at T, D read @0x0010 at T+1 -> d_rvalid at T+2, d_rdata=0xDEADBEEF; held after rvalid drops.
- I read @0x0020 (preloaded 0x12345678) at T, D write 0xFFFFFFFF @0x0020 at T+1 -> i_rvalid at T+1 with 0x12345678, no d_rvalid.
- Both requesting every cycle, STARVE=4, priority mode -> grant pattern D,D,D,D,I repeating; every read returns to the correct port.
- Same stimulus with MEM_ARB_RR_EN -> grants alternate I,D,I,D starting with I after reset.
- D read issued, rst_n pulsed low mid-cycle before next edge -> d_rvalid never asserts; d_rdata=0; first post-reset grant issues normally.
